// File: rtl/memory_stage_if.sv
// memory_stage_if: execute-to-memory inputs and memory-to-writeback outputs of memory_stage.
// Also holds the shared datapath widths and opcode encodings.
`ifndef REG_WIDTH
`define REG_WIDTH 16
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 16
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 8
`endif
`define OP_ADD   8'h00
`define OP_ADDI  8'h01
`define OP_AND   8'h02
`define OP_ANDI  8'h03
`define OP_MOV   8'h04
`define OP_MOVI  8'h05
`define OP_LDW   8'h06
`define OP_STW   8'h07
`define OP_BRN   8'h08
`define OP_BRZ   8'h09
`define OP_BRP   8'h0A
`define OP_BRNZ  8'h0B
`define OP_BRNP  8'h0C
`define OP_BRZP  8'h0D
`define OP_BRNZP 8'h0E
`define OP_JMP   8'h0F
`define OP_JSR   8'h10
`define OP_JSRR  8'h11
`define OP_NOP   8'h12

interface memory_stage_if;
    logic                     I_LOCK;
    logic [`REG_WIDTH-1:0]    I_ALUOut;
    logic [`OPCODE_WIDTH-1:0] I_Opcode;
    logic [3:0]               I_DestRegIdx;
    logic [`REG_WIDTH-1:0]    I_DestValue;
    logic                     I_FetchStall;
    logic                     I_DepStall;
    logic                     O_LOCK;
    logic [`REG_WIDTH-1:0]    O_ALUOut;
    logic [`OPCODE_WIDTH-1:0] O_Opcode;
    logic [3:0]               O_DestRegIdx;
    logic [`REG_WIDTH-1:0]    O_DestValue;
    logic [`REG_WIDTH-1:0]    O_MemOut;
    logic [`PC_WIDTH-1:0]     O_BranchPC;
    logic                     O_BranchAddrSelect;
    logic                     O_FetchStall;
    logic                     O_DepStall;
    logic [`REG_WIDTH-1:0]    O_LEDR;
    modport slave (
        input  I_LOCK, I_ALUOut, I_Opcode, I_DestRegIdx, I_DestValue, I_FetchStall, I_DepStall,
        output O_LOCK, O_ALUOut, O_Opcode, O_DestRegIdx, O_DestValue, O_MemOut, O_BranchPC,
               O_BranchAddrSelect, O_FetchStall, O_DepStall, O_LEDR
    );
    modport master (
        output I_LOCK, I_ALUOut, I_Opcode, I_DestRegIdx, I_DestValue, I_FetchStall, I_DepStall,
        input  O_LOCK, O_ALUOut, O_Opcode, O_DestRegIdx, O_DestValue, O_MemOut, O_BranchPC,
               O_BranchAddrSelect, O_FetchStall, O_DepStall, O_LEDR
    );
endinterface

// File: rtl/memory_stage.sv
// memory_stage: data-memory load/store, N/Z/P flags and branch redirect, registered on negedge.
// Optional MEM_LEDR_EN maps a store/load at LEDR_ADDR onto the O_LEDR register.
module memory_stage #(
    parameter int                    DMEM_ADDR_BITS = 10,
    parameter logic [`REG_WIDTH-1:0] LEDR_ADDR      = 16'hF000
) (
    input logic I_CLOCK,
    input logic I_RESET,
    memory_stage_if.slave bus
);
    logic [`REG_WIDTH-1:0] mem [1<<DMEM_ADDR_BITS];
    logic [DMEM_ADDR_BITS-1:0] idx;
    logic go, is_led, setf, taken;
    logic [`REG_WIDTH-1:0] ld_data, res;
    logic lock_q, lock_d, bsel_q, bsel_d, fs_q, fs_d, ds_q, ds_d;
    logic [`REG_WIDTH-1:0] alu_q, alu_d, dv_q, dv_d, mo_q, mo_d, ledr_q, ledr_d;
    logic [`OPCODE_WIDTH-1:0] op_q, op_d;
    logic [3:0] dst_q, dst_d;
    logic [`PC_WIDTH-1:0] bpc_q, bpc_d;
    logic [2:0] flg_q, flg_d;

    assign idx = bus.I_ALUOut[DMEM_ADDR_BITS+1:2];
    assign go = bus.I_LOCK & ~bus.I_FetchStall & ~bus.I_DepStall;
`ifdef MEM_LEDR_EN
    assign is_led = bus.I_ALUOut == LEDR_ADDR;
    assign bus.O_LEDR = ledr_q;
`else
    assign is_led = 1'b0;
    assign bus.O_LEDR = '0;
`endif
    assign ld_data = is_led ? ledr_q : mem[idx];
    assign res = bus.I_Opcode == `OP_LDW ? ld_data : bus.I_ALUOut;

    // flg_q = {N, Z, P}; taken uses the value before this edge
    always_comb begin
        setf = 1'b0;
        taken = 1'b0;
        case (bus.I_Opcode)
            `OP_ADD, `OP_ADDI, `OP_AND, `OP_ANDI, `OP_MOV, `OP_MOVI, `OP_LDW: setf = 1'b1;
            `OP_BRN:  taken = flg_q[2];
            `OP_BRZ:  taken = flg_q[1];
            `OP_BRP:  taken = flg_q[0];
            `OP_BRNZ: taken = flg_q[2] | flg_q[1];
            `OP_BRNP: taken = flg_q[2] | flg_q[0];
            `OP_BRZP: taken = flg_q[1] | flg_q[0];
            `OP_BRNZP, `OP_JMP, `OP_JSR, `OP_JSRR: taken = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        lock_d = bus.I_LOCK;
        bsel_d = 1'b0;
        fs_d = bus.I_LOCK ? bus.I_FetchStall : fs_q;
        ds_d = bus.I_LOCK ? bus.I_DepStall : ds_q;
        alu_d = go ? bus.I_ALUOut : alu_q;
        op_d = go ? bus.I_Opcode : op_q;
        dst_d = go ? bus.I_DestRegIdx : dst_q;
        dv_d = go ? bus.I_DestValue : dv_q;
        mo_d = go && bus.I_Opcode == `OP_LDW ? ld_data : mo_q;
        flg_d = go && setf ? {res[`REG_WIDTH-1], res == '0, ~res[`REG_WIDTH-1] & |res} : flg_q;
        bpc_d = go && taken ? bus.I_ALUOut[`PC_WIDTH-1:0] : bpc_q;
        ledr_d = go && is_led && bus.I_Opcode == `OP_STW ? bus.I_DestValue : ledr_q;
        if (go && taken) bsel_d = 1'b1;
    end

    always_ff @(negedge I_CLOCK)
        if (go && bus.I_Opcode == `OP_STW && !is_led) mem[idx] <= bus.I_DestValue;

    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            lock_q <= 1'b0;
            bsel_q <= 1'b0;
            fs_q <= 1'b0;
            ds_q <= 1'b0;
            alu_q <= '0;
            op_q <= '0;
            dst_q <= '0;
            dv_q <= '0;
            mo_q <= '0;
            bpc_q <= '0;
            ledr_q <= '0;
            flg_q <= 3'b010;
        end else begin
            lock_q <= lock_d;
            bsel_q <= bsel_d;
            fs_q <= fs_d;
            ds_q <= ds_d;
            alu_q <= alu_d;
            op_q <= op_d;
            dst_q <= dst_d;
            dv_q <= dv_d;
            mo_q <= mo_d;
            bpc_q <= bpc_d;
            ledr_q <= ledr_d;
            flg_q <= flg_d;
        end
    end

    assign bus.O_LOCK = lock_q;
    assign bus.O_BranchAddrSelect = bsel_q;
    assign bus.O_FetchStall = fs_q;
    assign bus.O_DepStall = ds_q;
    assign bus.O_ALUOut = alu_q;
    assign bus.O_Opcode = op_q;
    assign bus.O_DestRegIdx = dst_q;
    assign bus.O_DestValue = dv_q;
    assign bus.O_MemOut = mo_q;
    assign bus.O_BranchPC = bpc_q;
endmodule
